// File: rtl/cache_pkg.sv
// Shared types and line geometry for the data-cache miss controller.
package cache_pkg;

    typedef enum logic [1:0] {IDLE, WB, REFILL, UPDATE} miss_state_t;

    localparam int WORDS_PER_LINE_DEF = 4;
    localparam int LINE_BYTES         = 4 * WORDS_PER_LINE_DEF;

    // Line-aligned base of a byte address; line_bytes must be a power of 2.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int line_bytes);
        return addr & ~(32'(line_bytes) - 32'd1);
    endfunction

endpackage

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: dirty-victim writeback, then line refill over a
// req/ack memory port, then a single-cycle line install pulse to the cache.
module dcache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int CNT_W          = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           miss,
    input  logic [31:0]                    miss_addr,
    input  logic                           victim_dirty,
    input  logic [31:0]                    victim_addr,
    input  logic [WORDS_PER_LINE-1:0][31:0] victim_words,
    input  logic                           mem_ack,
    input  logic [31:0]                    mem_rdata,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [31:0]                    mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic                           update,
    output logic [WORDS_PER_LINE-1:0][31:0] line_words,
    output logic [31:0]                    line_addr,
    output logic                           stall,
    output logic [CNT_W-1:0]               miss_cnt,
    output logic [CNT_W-1:0]               wb_cnt
);

    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int LINE_B = 4 * WORDS_PER_LINE;

    typedef logic [WORDS_PER_LINE-1:0][31:0] line_t;

    miss_state_t       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [31:0]       miss_base_q, miss_base_d;
    logic [31:0]       victim_base_q, victim_base_d;
    logic [31:0]       line_addr_q, line_addr_d;
    line_t             victim_buf_q, victim_buf_d;
    line_t             line_buf_q, line_buf_d;
    line_t             line_words_q, line_words_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;

    logic        last_beat;
    logic [31:0] beat_off;

    assign last_beat = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));
    assign beat_off  = {{(30 - BEAT_W){1'b0}}, beat_q, 2'b00};

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d       = state_q;
        beat_d        = beat_q;
        miss_base_d   = miss_base_q;
        victim_base_d = victim_base_q;
        line_addr_d   = line_addr_q;
        victim_buf_d  = victim_buf_q;
        line_buf_d    = line_buf_q;
        line_words_d  = line_words_q;
        miss_cnt_d    = miss_cnt_q;
        wb_cnt_d      = wb_cnt_q;

        case (state_q)
            IDLE: begin
                if (miss) begin
                    miss_base_d   = line_base(miss_addr, LINE_B);
                    victim_base_d = line_base(victim_addr, LINE_B);
                    victim_buf_d  = victim_words;
                    beat_d        = '0;
                    state_d       = victim_dirty ? WB : REFILL;
                end
            end
            WB: begin
                if (mem_ack) begin
                    if (last_beat) begin
                        beat_d   = '0;
                        wb_cnt_d = (wb_cnt_q == '1) ? wb_cnt_q : wb_cnt_q + CNT_W'(1);
                        state_d  = REFILL;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    line_buf_d[beat_q] = mem_rdata;
                    beat_d             = beat_q + BEAT_W'(1);
                    // Publish the whole line at once so line_words never shows a partial fill.
                    if (last_beat) begin
                        line_words_d = line_buf_d;
                        line_addr_d  = miss_base_q;
                        state_d      = UPDATE;
                    end
                end
            end
            UPDATE: begin
                miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the line buffers are plain flops and are reset so line_words reads 0 out of reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            miss_base_q   <= '0;
            victim_base_q <= '0;
            line_addr_q   <= '0;
            victim_buf_q  <= '0;
            line_buf_q    <= '0;
            line_words_q  <= '0;
            miss_cnt_q    <= '0;
            wb_cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
            state_q       <= state_d;
            beat_q        <= beat_d;
            miss_base_q   <= miss_base_d;
            victim_base_q <= victim_base_d;
            line_addr_q   <= line_addr_d;
            victim_buf_q  <= victim_buf_d;
            line_buf_q    <= line_buf_d;
            line_words_q  <= line_words_d;
            miss_cnt_q    <= miss_cnt_d;
            wb_cnt_q      <= wb_cnt_d;
        end
    end

    // Beat outputs are decoded from registered state only, so they hold until ack.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            WB: begin
                mem_addr  = victim_base_q + beat_off;
                mem_wdata = victim_buf_q[beat_q];
            end
            REFILL:  mem_addr = miss_base_q + beat_off;
            default: ;
        endcase
    end

    assign mem_req    = (state_q == WB) || (state_q == REFILL);
    assign mem_we     = (state_q == WB);
    assign update     = (state_q == UPDATE);
    assign line_addr  = line_addr_q;
    assign line_words = line_words_q;
    assign stall      = miss | (state_q != IDLE);
    assign miss_cnt   = miss_cnt_q;
    assign wb_cnt     = wb_cnt_q;

endmodule
